// File: rtl/spi_master_arbiter.sv
// Two-requester front end for a shared SPI byte engine: round-robin grant,
// chip-select setup/hold/gap sequencing and per-byte start/done handshakes.
module spi_master_arbiter #(
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned CS_GAP   = 4,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic       clk,
    input  logic       btn_reset,
    input  logic       r0_valid,
    input  logic [7:0] r0_data,
    input  logic       r0_last,
    output logic       r0_ready,
    output logic       r0_rx_valid,
    input  logic       r1_valid,
    input  logic [7:0] r1_data,
    input  logic       r1_last,
    output logic       r1_ready,
    output logic       r1_rx_valid,
    output logic [7:0] rx_data,
    output logic       spi_start,
    output logic [7:0] spi_tx_data,
    input  logic       spi_done,
    input  logic [7:0] spi_rx_data,
    output logic       ss_n,
    output logic [1:0] grant,
    output logic       busy,
    output logic       abort
);

    localparam int unsigned PhaseMax = (CS_SETUP > CS_HOLD) ?
        ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP) :
        ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
    localparam int unsigned PW = $clog2(PhaseMax + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] SetupEnd = PW'(CS_SETUP - 1);
    localparam logic [PW-1:0] HoldEnd  = PW'(CS_HOLD - 1);
    localparam logic [PW-1:0] GapEnd   = PW'(CS_GAP - 1);
    localparam logic [TW-1:0] TmoEnd   = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StLoad, StXfer, StHold, StGap} state_e;

    state_e        state_q, state_d;
    logic          own_q, own_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic          rr_seen_q, rr_seen_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          last_q, last_d;
    logic [7:0]    tx_q, tx_d;
    logic [7:0]    rx_q, rx_d;
    logic          accept, timeout, done_hit;

    logic       ss_n_q, ss_n_d, busy_q, busy_d, start_q, start_d, abort_q, abort_d;
    logic       r0_ready_q, r0_ready_d, r1_ready_q, r1_ready_d;
    logic       r0_rxv_q, r0_rxv_d, r1_rxv_q, r1_rxv_d;
    logic [1:0] grant_q, grant_d;
    logic       in_txn;

    logic       sel_valid, sel_last;
    logic [7:0] sel_data;

    assign sel_valid = own_q ? r1_valid : r0_valid;
    assign sel_last  = own_q ? r1_last  : r0_last;
    assign sel_data  = own_q ? r1_data  : r0_data;

    always_ff @(posedge clk or negedge btn_reset) begin
        if (!btn_reset) begin
            state_q    <= StIdle;
            own_q      <= 1'b0;
            rr_ptr_q   <= 1'b0;
            rr_seen_q  <= 1'b0;
            pcnt_q     <= '0;
            tcnt_q     <= '0;
            last_q     <= 1'b0;
            tx_q       <= 8'h00;
            rx_q       <= 8'h00;
            ss_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            grant_q    <= 2'b00;
            start_q    <= 1'b0;
            abort_q    <= 1'b0;
            r0_ready_q <= 1'b0;
            r1_ready_q <= 1'b0;
            r0_rxv_q   <= 1'b0;
            r1_rxv_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            own_q      <= own_d;
            rr_ptr_q   <= rr_ptr_d;
            rr_seen_q  <= rr_seen_d;
            pcnt_q     <= pcnt_d;
            tcnt_q     <= tcnt_d;
            last_q     <= last_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            ss_n_q     <= ss_n_d;
            busy_q     <= busy_d;
            grant_q    <= grant_d;
            start_q    <= start_d;
            abort_q    <= abort_d;
            r0_ready_q <= r0_ready_d;
            r1_ready_q <= r1_ready_d;
            r0_rxv_q   <= r0_rxv_d;
            r1_rxv_q   <= r1_rxv_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        own_d     = own_q;
        rr_ptr_d  = rr_ptr_q;
        rr_seen_d = rr_seen_q;
        pcnt_d    = pcnt_q;
        tcnt_d    = tcnt_q;
        last_d    = last_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        accept    = 1'b0;
        timeout   = 1'b0;
        done_hit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (r0_valid || r1_valid) begin
                    // Ties alternate away from the last owner; r0 wins the first tie after reset.
                    if (r0_valid && r1_valid) own_d = rr_seen_q ? ~rr_ptr_q : 1'b0;
                    else                      own_d = r1_valid;
                    rr_ptr_d  = own_d;
                    rr_seen_d = 1'b1;
                    pcnt_d    = '0;
                    state_d   = StSetup;
                end
            end
            StSetup: begin
                if (pcnt_q == SetupEnd) begin
                    pcnt_d  = '0;
                    tcnt_d  = '0;
                    state_d = StLoad;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            StLoad: begin
                if (sel_valid) begin
                    accept  = 1'b1;
                    tx_d    = sel_data;
                    last_d  = sel_last;
                    state_d = StXfer;
                end else if (tcnt_q == TmoEnd) begin
                    timeout = 1'b1;
                    pcnt_d  = '0;
                    state_d = StHold;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            StXfer: begin
                if (spi_done) begin
                    done_hit = 1'b1;
                    rx_d     = spi_rx_data;
                    if (last_q) begin
                        pcnt_d  = '0;
                        state_d = StHold;
                    end else begin
                        tcnt_d  = '0;
                        state_d = StLoad;
                    end
                end
            end
            StHold: begin
                if (pcnt_q == HoldEnd) begin
                    pcnt_d  = '0;
                    state_d = StGap;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            StGap: begin
                if (pcnt_q == GapEnd) begin
                    pcnt_d  = '0;
                    state_d = StIdle;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are computed from the next state so they register alongside it.
    always_comb begin
        in_txn     = state_d inside {StSetup, StLoad, StXfer, StHold};
        ss_n_d     = ~in_txn;
        busy_d     = (state_d != StIdle);
        grant_d    = in_txn ? (own_d ? 2'b10 : 2'b01) : 2'b00;
        r0_ready_d = (state_d == StLoad) && !own_d;
        r1_ready_d = (state_d == StLoad) && own_d;
        start_d    = accept;
        abort_d    = timeout;
        r0_rxv_d   = done_hit && !own_q;
        r1_rxv_d   = done_hit && own_q;
    end

    assign r0_ready    = r0_ready_q;
    assign r1_ready    = r1_ready_q;
    assign r0_rx_valid = r0_rxv_q;
    assign r1_rx_valid = r1_rxv_q;
    assign rx_data     = rx_q;
    assign spi_start   = start_q;
    assign spi_tx_data = tx_q;
    assign ss_n        = ss_n_q;
    assign grant       = grant_q;
    assign busy        = busy_q;
    assign abort       = abort_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Scoreboard bench for spi_master_arbiter: tx bytes checked at spi_start,
// rx bytes and owner checked at rx_valid, plus CS timing and grant order.
module tb_spi_master_arbiter;

    localparam int EngLat = 16;

    logic       clk = 1'b0;
    logic       btn_reset;
    logic       r0_valid, r0_last, r0_ready, r0_rx_valid;
    logic       r1_valid, r1_last, r1_ready, r1_rx_valid;
    logic [7:0] r0_data, r1_data, rx_data, spi_tx_data, spi_rx_data;
    logic       spi_start, spi_done, ss_n, busy, abort;
    logic [1:0] grant;

    always #5 clk = ~clk;

    spi_master_arbiter dut (
        .clk         (clk),
        .btn_reset   (btn_reset),
        .r0_valid    (r0_valid),
        .r0_data     (r0_data),
        .r0_last     (r0_last),
        .r0_ready    (r0_ready),
        .r0_rx_valid (r0_rx_valid),
        .r1_valid    (r1_valid),
        .r1_data     (r1_data),
        .r1_last     (r1_last),
        .r1_ready    (r1_ready),
        .r1_rx_valid (r1_rx_valid),
        .rx_data     (rx_data),
        .spi_start   (spi_start),
        .spi_tx_data (spi_tx_data),
        .spi_done    (spi_done),
        .spi_rx_data (spi_rx_data),
        .ss_n        (ss_n),
        .grant       (grant),
        .busy        (busy),
        .abort       (abort)
    );

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] tx_q[$];
    logic [8:0] rx_q[$];
    logic [1:0] grant_log[$];

    int starts = 0, aborts = 0, ss_rises = 0, ready_viol = 0, rx_seen = 0;
    int inject_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input bit idx, input logic [7:0] data, input bit last);
        int n = 0;
        bit ok = 1'b0;
        if (idx) begin r1_valid = 1'b1; r1_data = data; r1_last = last; end
        else     begin r0_valid = 1'b1; r0_data = data; r0_last = last; end
        while (n < 2000 && !ok) begin
            @(negedge clk);
            n++;
            ok = idx ? r1_ready : r0_ready;
        end
        if (!ok) begin
            check(idx ? "r1_accept" : "r0_accept", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
            tx_q.push_back(data);
            rx_q.push_back({idx, data ^ 8'h99});
        end
        #1;
        if (idx) r1_valid = 1'b0;
        else     r0_valid = 1'b0;
    endtask

    // sel: 0 abort, 1 r0_rx_valid, 2 ss_n high, 3 busy low, 4 spi_start, 5 r1_rx_valid, 6 ss_n low
    task automatic wait_until(input int sel, input int limit, output int n);
        bit hit;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            case (sel)
                0:       hit = abort;
                1:       hit = r0_rx_valid;
                2:       hit = ss_n;
                3:       hit = !busy;
                4:       hit = spi_start;
                5:       hit = r1_rx_valid;
                6:       hit = !ss_n;
                default: hit = 1'b1;
            endcase
        end while (!hit && n < limit);
        if (!hit) n = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        btn_reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        btn_reset = 1'b1;
    endtask

    // SPI engine model: echoes tx ^ 8'h99 after EngLat cycles.
    initial begin
        int served = 0;
        logic [7:0] echo;
        spi_done = 1'b0;
        spi_rx_data = 8'h00;
        forever begin
            @(negedge clk);
            if (spi_start) begin
                if (tx_q.size() == 0) check("start_unexpected", {31'd0, spi_start}, 32'd0);
                else                  check("spi_tx_data", {24'd0, spi_tx_data}, {24'd0, tx_q.pop_front()});
                echo = spi_tx_data ^ 8'h99;
                repeat (EngLat) @(negedge clk);
                spi_done = 1'b1;
                spi_rx_data = echo;
                @(negedge clk);
                spi_done = 1'b0;
                spi_rx_data = 8'h00;
            end else if (inject_cnt != served) begin
                served++;
                spi_done = 1'b1;
                spi_rx_data = 8'hEE;
                @(negedge clk);
                spi_done = 1'b0;
                spi_rx_data = 8'h00;
            end
        end
    end

    initial begin
        logic [1:0] gprev = 2'b00;
        logic ss_prev = 1'b1;
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (spi_start) starts++;
            if (abort) aborts++;
            if (!ss_prev && ss_n) ss_rises++;
            ss_prev = ss_n;
            if (r0_ready && grant != 2'b01) ready_viol++;
            if (r1_ready && grant != 2'b10) ready_viol++;
            if (grant != gprev && grant != 2'b00) grant_log.push_back(grant);
            gprev = grant;
            if (r0_rx_valid || r1_rx_valid) begin
                rx_seen++;
                check("rx_valid_onehot", {31'd0, r0_rx_valid & r1_rx_valid}, 32'd0);
                if (rx_q.size() == 0) begin
                    check("rx_valid_unexpected", {30'd0, r1_rx_valid, r0_rx_valid}, 32'd0);
                end else begin
                    e = rx_q.pop_front();
                    check("rx_owner", {31'd0, r1_rx_valid}, {31'd0, e[8]});
                    check("rx_data", {24'd0, rx_data}, {24'd0, e[7:0]});
                end
            end
        end
    end

    int n, s0, s1, s2, s3, g0;
    int k_lo, k_start, k_rx, k_hi, k_idle;

    initial begin
        btn_reset = 1'b0;
        r0_valid = 1'b0; r0_data = 8'h00; r0_last = 1'b0;
        r1_valid = 1'b0; r1_data = 8'h00; r1_last = 1'b0;
        #22;
        check("rst_ss_n", {31'd0, ss_n}, 32'd1);
        check("rst_grant_busy", {29'd0, grant, busy}, 32'd0);
        check("rst_pulses", {26'd0, r0_ready, r1_ready, r0_rx_valid, r1_rx_valid, spi_start, abort},
              32'd0);
        check("rst_data", {16'd0, spi_tx_data, rx_data}, 32'd0);
        @(negedge clk);
        btn_reset = 1'b1;

        // Round-robin on ties: r0, r1, then r0, r1 again.
        g0 = grant_log.size();
        fork
            send_byte(1'b0, 8'h01, 1'b1);
            send_byte(1'b1, 8'h02, 1'b1);
        join
        wait_until(3, 200, n);
        check("t2_idle_a", n > 0, 1);
        fork
            send_byte(1'b0, 8'h03, 1'b1);
            send_byte(1'b1, 8'h04, 1'b1);
        join
        wait_until(3, 200, n);
        check("t2_idle_b", n > 0, 1);
        check("t2_grants", grant_log.size() - g0, 4);
        if (grant_log.size() - g0 == 4) begin
            check("t2_g0", {30'd0, grant_log[g0]},     32'd1);
            check("t2_g1", {30'd0, grant_log[g0 + 1]}, 32'd2);
            check("t2_g2", {30'd0, grant_log[g0 + 2]}, 32'd1);
            check("t2_g3", {30'd0, grant_log[g0 + 3]}, 32'd2);
        end

        // Single byte from r0 with exact CS and handshake timing.
        k_lo = -1; k_start = -1; k_rx = -1; k_hi = -1; k_idle = -1;
        @(posedge clk);
        #1;
        fork
            send_byte(1'b0, 8'hA5, 1'b1);
        join_none
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k_lo < 0 && !ss_n) k_lo = k;
            if (k_start < 0 && spi_start) k_start = k;
            if (k_rx < 0 && r0_rx_valid) begin
                k_rx = k;
                check("t1_rx_3c", {24'd0, rx_data}, 32'h3c);
            end
            if (k_lo >= 0 && k_hi < 0 && ss_n) k_hi = k;
            if (k_lo >= 0 && k_idle < 0 && !busy) k_idle = k;
        end
        check("t1_ss_low", k_lo, 1);
        check("t1_start", k_start, 4);
        check("t1_rx_valid", k_rx, 5 + EngLat);
        check("t1_ss_high", k_hi, 7 + EngLat);
        check("t1_idle", k_idle, 11 + EngLat);

        // r1 three-byte burst under one chip select.
        s0 = starts; s1 = rx_seen; s2 = ss_rises; s3 = ready_viol;
        send_byte(1'b1, 8'h11, 1'b0);
        send_byte(1'b1, 8'h22, 1'b0);
        send_byte(1'b1, 8'h33, 1'b1);
        wait_until(3, 200, n);
        check("t3_idle", n > 0, 1);
        check("t3_starts", starts - s0, 3);
        check("t3_rx", rx_seen - s1, 3);
        check("t3_ss_rises", ss_rises - s2, 1);
        check("t3_ready_viol", ready_viol - s3, 0);

        // Abort when the next byte never arrives.
        s0 = aborts;
        fork
            send_byte(1'b0, 8'h5A, 1'b0);
        join_none
        wait_until(1, 100, n);
        check("t4_rx_seen", n > 0, 1);
        wait_until(0, 1100, n);
        check("t4_abort_latency", n, 1024);
        wait_until(2, 10, n);
        check("t4_ss_high", n, 2);
        wait_until(3, 10, n);
        check("t4_idle", n, 4);
        check("t4_abort_count", aborts - s0, 1);

        // Reset during XFER, then a stray spi_done.
        fork
            send_byte(1'b1, 8'h77, 1'b1);
        join_none
        wait_until(4, 50, n);
        check("t5_start", n > 0, 1);
        @(posedge clk);
        #2;
        btn_reset = 1'b0;
        #1;
        check("t5_ss_n", {31'd0, ss_n}, 32'd1);
        check("t5_grant", {30'd0, grant}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        rx_q.delete();
        @(negedge clk);
        btn_reset = 1'b1;
        s0 = starts; s1 = rx_seen;
        k_idle = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (busy || !ss_n) k_idle++;
        end
        check("t5_no_rx", rx_seen - s1, 0);
        check("t5_no_start", starts - s0, 0);
        check("t5_stays_idle", k_idle, 0);

        // spi_done injected in GAP and in IDLE is ignored.
        s1 = rx_seen;
        fork
            send_byte(1'b0, 8'h42, 1'b1);
        join_none
        wait_until(6, 50, n);
        wait_until(1, 50, n);
        check("t6_rx", n > 0, 1);
        wait_until(2, 10, n);
        check("t6_gap", n, 2);
        inject_cnt++;
        wait_until(3, 10, n);
        check("t6_gap_len", n, 4);
        inject_cnt++;
        repeat (5) @(negedge clk);
        check("t6_idle_state", {28'd0, busy, ss_n, grant}, 32'h4);
        check("t6_rx_count", rx_seen - s1, 1);

        do_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
